mult_rr_scheduler: RTL and testbench
====================================

Name: mult_rr_scheduler

Overview:
- Round-robin scheduler that shares one vdic_dut_2023 signed 16x16 parity-checked multiplier between N_REQ requesters.
- Sits between requester agents and the multiplier.
- Sequences the multiplier's req/ack and result_rdy handshake and routes each result back to the requester that issued it.
- Provides timeout watchdog recovery: if the multiplier hangs, the scheduler resets it and returns a timeout response.

Parameters:
N_REQ, 4, number of requesters; legal range 2..16
TIMEOUT_CYCLES, 64, maximum cycles spent in ISSUE+WAIT before recovery; must be >= 4

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  requester i has an operation pending; held until req_ready[i]
req_arg_a  in  16*N_REQ  signed operand A; requester i at [16i+15:16i]
req_arg_a_parity  in  N_REQ  even-parity bit of A (^A)
req_arg_b  in  16*N_REQ  signed operand B, same packing
req_arg_b_parity  in  N_REQ  parity bit of B
req_ready  out  N_REQ  one-cycle pulse: operation of requester i captured
rsp_valid  out  N_REQ  one-cycle pulse: response for requester i
rsp_id  out  $clog2(N_REQ)  index of the responding requester
rsp_result  out  32  product; 0 on parity error or timeout
rsp_result_parity  out  1  ^rsp_result as reported by the multiplier (0 on timeout)
rsp_parity_error  out  1  multiplier flagged an argument parity error
rsp_timeout  out  1  operation aborted by the watchdog
busy  out  1  high in every state except IDLE
m_rst_n  out  1  multiplier reset, active-low; = !(rst | recover pulse)
m_req, m_arg_a[16], m_arg_a_parity, m_arg_b[16], m_arg_b_parity  out  multiplier request side
m_ack, m_result[32], m_result_parity, m_result_rdy, m_arg_parity_error  in  multiplier response side

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, rr pointer=0, timeout counter=0.
  - All outputs 0 except m_rst_n=0 while rst is high.
- States: IDLE, ISSUE, WAIT, RECOVER, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching ptr, ptr+1, ... mod N_REQ.
  - Capture the granted operands, parities and index into internal registers, then go to ISSUE.
  - With no req_valid, stay in IDLE.
- ISSUE:
  - req_ready[g] pulses high in the first ISSUE cycle only.
  - The requester must drop or replace req_valid[g] at that edge.
  - m_req=1 with captured args held stable until m_ack is sampled high.
  - On m_ack: go to WAIT; m_req=0 from the next cycle.
  - An m_result_rdy arriving before m_ack is ignored.
- WAIT:
  - m_req=0.
  - On m_result_rdy: capture m_result, m_result_parity and m_arg_parity_error, then go to RESP.
- Timeout:
  - Counter clears on ISSUE entry and increments every ISSUE/WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without m_ack (ISSUE) or m_result_rdy (WAIT), go to RECOVER.
  - Completion in the same cycle as expiry wins: normal response, no timeout.
- RECOVER:
  - One cycle with m_rst_n=0 and m_req=0.
  - Set result=0, parity=0, timeout=1, then go to RESP.
- RESP:
  - One cycle: rsp_valid[g]=1; rsp_id, rsp_result, rsp_result_parity, rsp_parity_error and rsp_timeout driven from the captured registers.
  - Response data is 0 outside RESP.
  - ptr <= (g+1) mod N_REQ; go to IDLE.
- Latency:
  - Valid sampled in IDLE at cycle T: m_req high at T+1.
  - If m_ack at T+1 and m_result_rdy at cycle R: rsp_valid at R+1, next grant sampled at R+2.
  - Minimum request-to-response is 3 cycles.
- Single operation outstanding; no pipelining.
  - req_valid of non-granted requesters is ignored until IDLE.
- Only the grant-time req_valid matters: a request dropped before grant is simply not served.
- Reset mid-operation aborts silently: no rsp_valid, ptr=0, multiplier held in reset.
- Operands and result are passed unmodified.
  - The scheduler never computes or checks parity itself.
  - The multiplier's product is signed 16x16 -> 32.

Test Plan:
- Single op: requester 1, A=3 (par 0), B=-5 (0xFFFB, par 1), model acks next cycle and returns after 2 cycles -> rsp_valid[1], rsp_id=1, rsp_result=0xFFFFFFF1, rsp_result_parity=1, error=0, timeout=0; req_ready[1] pulses exactly once.
- Parity error: requester 0, A=0x0001 with parity 0 -> multiplier flags it -> rsp_parity_error=1, rsp_result=0, ptr advances to 1.
- Fairness: all four req_valid held continuously from reset, each requester reissuing after its ready -> grant order 0,1,2,3,0,1,...; then with only requesters 0 and 2 valid and ptr=0 -> order 0,2,0,2.
- Timeout: model never raises m_result_rdy after ack -> after TIMEOUT_CYCLES ISSUE+WAIT cycles, m_rst_n low for exactly one cycle, then rsp_valid with rsp_timeout=1, result 0. Repeat with m_ack withheld in ISSUE -> same response. The next request completes normally.
- Boundary: m_result_rdy coincident with counter expiry (cycle 63) -> normal response, m_rst_n stays 1. m_result_rdy pulsed during ISSUE before m_ack -> ignored.
- Reset mid-WAIT: rst=1 for one cycle while in WAIT -> no rsp_valid; busy=0 and outputs 0 next cycle. m_rst_n low during rst. ptr=0, so requester 0 wins the next simultaneous request with requester 3.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin sharing of one signed 16x16 parity-checked multiplier among N_REQ requesters,
// with a watchdog that resets a hung multiplier and answers with a timeout response.
module mult_rr_scheduler #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [16*N_REQ-1:0]      req_arg_a,
    input  logic [N_REQ-1:0]         req_arg_a_parity,
    input  logic [16*N_REQ-1:0]      req_arg_b,
    input  logic [N_REQ-1:0]         req_arg_b_parity,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [31:0]              rsp_result,
    output logic                     rsp_result_parity,
    output logic                     rsp_parity_error,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic                     m_rst_n,
    output logic                     m_req,
    output logic [15:0]              m_arg_a,
    output logic                     m_arg_a_parity,
    output logic [15:0]              m_arg_b,
    output logic                     m_arg_b_parity,
    input  logic                     m_ack,
    input  logic [31:0]              m_result,
    input  logic                     m_result_parity,
    input  logic                     m_result_rdy,
    input  logic                     m_arg_parity_error
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RECOVER, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr, g, gnt, idx;
    logic [CW-1:0] cnt;
    logic          expired;

    assign expired = cnt >= CW'(TIMEOUT_CYCLES - 1);
    assign busy    = state != IDLE;
    assign m_rst_n = !(rst || state == RECOVER);

    // Scan downward so the requester closest to ptr is assigned last and wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((32'(ptr) + 32'(k)) % N_REQ);
            if (req_valid[idx]) gnt = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            ptr               <= '0;
            g                 <= '0;
            cnt               <= '0;
            req_ready         <= '0;
            rsp_valid         <= '0;
            rsp_id            <= '0;
            rsp_result        <= '0;
            rsp_result_parity <= 1'b0;
            rsp_parity_error  <= 1'b0;
            rsp_timeout       <= 1'b0;
            m_req             <= 1'b0;
            m_arg_a           <= '0;
            m_arg_a_parity    <= 1'b0;
            m_arg_b           <= '0;
            m_arg_b_parity    <= 1'b0;
        end else begin
            req_ready         <= '0;
            rsp_valid         <= '0;
            rsp_id            <= '0;
            rsp_result        <= '0;
            rsp_result_parity <= 1'b0;
            rsp_parity_error  <= 1'b0;
            rsp_timeout       <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    g              <= gnt;
                    m_arg_a        <= req_arg_a[16*gnt +: 16];
                    m_arg_a_parity <= req_arg_a_parity[gnt];
                    m_arg_b        <= req_arg_b[16*gnt +: 16];
                    m_arg_b_parity <= req_arg_b_parity[gnt];
                    req_ready      <= N_REQ'(1) << gnt;
                    m_req          <= 1'b1;
                    cnt            <= '0;
                    state          <= ISSUE;
                end
                ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= WAIT;
                    end else if (expired) begin
                        m_req <= 1'b0;
                        state <= RECOVER;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A completion in the expiry cycle still counts as a normal response.
                    if (m_result_rdy) begin
                        rsp_valid         <= N_REQ'(1) << g;
                        rsp_id            <= g;
                        rsp_result        <= m_result;
                        rsp_result_parity <= m_result_parity;
                        rsp_parity_error  <= m_arg_parity_error;
                        state             <= RESP;
                    end else if (expired) begin
                        state <= RECOVER;
                    end
                end
                RECOVER: begin
                    rsp_valid   <= N_REQ'(1) << g;
                    rsp_id      <= g;
                    rsp_timeout <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    ptr   <= (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: timeline model of grants/responses plus a behavioural multiplier,
// checked every cycle, with directed literal expectations per scenario.
module tb_mult_rr_scheduler;
    localparam int N  = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid, req_a_par, req_b_par, req_ready, rsp_valid;
    logic [16*N-1:0] req_a, req_b;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_result_parity, rsp_parity_error, rsp_timeout, busy, m_rst_n;
    logic            m_req, m_arg_a_parity, m_arg_b_parity;
    logic [15:0]     m_arg_a, m_arg_b;
    logic            m_ack = 1'b0, m_result_parity = 1'b0, m_result_rdy = 1'b0, m_arg_parity_error = 1'b0;
    logic [31:0]     m_result = '0;

    mult_rr_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_arg_a(req_a), .req_arg_a_parity(req_a_par),
        .req_arg_b(req_b), .req_arg_b_parity(req_b_par), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_result_parity(rsp_result_parity), .rsp_parity_error(rsp_parity_error),
        .rsp_timeout(rsp_timeout), .busy(busy), .m_rst_n(m_rst_n), .m_req(m_req),
        .m_arg_a(m_arg_a), .m_arg_a_parity(m_arg_a_parity), .m_arg_b(m_arg_b),
        .m_arg_b_parity(m_arg_b_parity), .m_ack(m_ack), .m_result(m_result),
        .m_result_parity(m_result_parity), .m_result_rdy(m_result_rdy),
        .m_arg_parity_error(m_arg_parity_error)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Requesters: want[i] operations requested by the test, issued[i] counted from req_ready.
    int          want[N], issued[N];
    logic [15:0] op_a[N], op_b[N];
    logic        op_ap[N], op_bp[N];

    initial for (int i = 0; i < N; i++) issued[i] = 0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = issued[i] < want[i];
            req_a[16*i +: 16]   = op_a[i];
            req_b[16*i +: 16]   = op_b[i];
            req_a_par[i]        = op_ap[i];
            req_b_par[i]        = op_bp[i];
        end
    end

    always @(negedge clk)
        for (int i = 0; i < N; i++) if (req_ready[i]) issued[i]++;

    // Multiplier behaviour, configured per operation.
    int  ack_d = 0, res_d = 1;
    bit  ack_never = 0, res_never = 0, early = 0;
    int  ph = 0, mc = 0;
    logic [15:0] ma, mb;
    logic mperr;

    always @(negedge clk) begin
        m_ack = 0; m_result_rdy = 0; m_result = '0; m_result_parity = 0; m_arg_parity_error = 0;
        if (!m_rst_n) ph = 0;
        else begin
            if (ph == 0 && m_req) begin
                ph = 1; mc = 0; ma = m_arg_a; mb = m_arg_b;
                mperr = (^m_arg_a != m_arg_a_parity) || (^m_arg_b != m_arg_b_parity);
            end
            if (ph == 1) begin
                mc++;
                if (!ack_never && mc == ack_d + 1) begin
                    m_ack = 1; ph = 2; mc = 0;
                end else if (early && mc == 1) begin
                    m_result_rdy = 1; m_result = 32'hDEADBEEF; m_result_parity = 1;
                end
            end else if (ph == 2) begin
                mc++;
                if (!res_never && mc == res_d) begin
                    m_result_rdy = 1;
                    m_result = mperr ? 32'd0 : 32'($signed(ma) * $signed(mb));
                    m_result_parity = ^m_result;
                    m_arg_parity_error = mperr;
                    ph = 0;
                end
            end
        end
    end

    // Scheduler model: one operation at a time, described as a timeline of edge numbers.
    int   cyc = 0, mptr = 0, next_free = 0;
    bit   have = 0;
    int   x_g, e_grant, e_mreq_last, e_rec, e_rsp;
    logic [31:0] x_res;
    logic x_par, x_perr, x_to;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            have = 0; mptr = 0; next_free = cyc + 1;
        end else if (cyc >= next_free && req_valid != 0) begin
            x_g = -1;
            for (int k = N - 1; k >= 0; k--) if (req_valid[(mptr + k) % N]) x_g = (mptr + k) % N;
            mptr = (x_g + 1) % N;
            have = 1; e_grant = cyc;
            x_perr = (^op_a[x_g] != op_ap[x_g]) || (^op_b[x_g] != op_bp[x_g]);
            if (ack_never || ack_d > TO - 1) begin
                x_to = 1; e_mreq_last = cyc + TO - 1;
            end else begin
                x_to = res_never || (ack_d + res_d > TO - 1); e_mreq_last = cyc + ack_d;
            end
            e_rec = x_to ? cyc + TO : -10;
            e_rsp = x_to ? cyc + TO + 1 : cyc + ack_d + res_d + 1;
            x_res = (x_to || x_perr) ? 32'd0 : 32'($signed(op_a[x_g]) * $signed(op_b[x_g]));
            x_par = ^x_res;
            next_free = e_rsp + 2;
        end
    end

    logic [N-1:0] oh;
    bit is_rsp, mr;
    always @(negedge clk) if (cyc >= 1) begin
        oh     = have ? N'(1) << x_g : '0;
        is_rsp = have && cyc == e_rsp;
        mr     = have && cyc >= e_grant && cyc <= e_mreq_last;
        chk("req_ready", 32'(req_ready), (have && cyc == e_grant) ? 32'(oh) : 0);
        chk("rsp_valid", 32'(rsp_valid), is_rsp ? 32'(oh) : 0);
        chk("rsp_id", 32'(rsp_id), is_rsp ? 32'(x_g) : 0);
        chk("rsp_result", rsp_result, is_rsp ? x_res : 0);
        chk("rsp_result_parity", 32'(rsp_result_parity), is_rsp ? 32'(x_par) : 0);
        chk("rsp_parity_error", 32'(rsp_parity_error), is_rsp ? 32'(x_perr) : 0);
        chk("rsp_timeout", 32'(rsp_timeout), is_rsp ? 32'(x_to) : 0);
        chk("busy", 32'(busy), 32'(have && cyc >= e_grant && cyc <= e_rsp));
        chk("m_req", 32'(m_req), 32'(mr));
        chk("m_rst_n", 32'(m_rst_n), 32'(!(rst || (have && x_to && cyc == e_rec))));
        if (mr) begin
            chk("m_arg_a", 32'(m_arg_a), 32'(op_a[x_g]));
            chk("m_arg_b", 32'(m_arg_b), 32'(op_b[x_g]));
            chk("m_arg_par", {30'd0, m_arg_a_parity, m_arg_b_parity}, {30'd0, op_ap[x_g], op_bp[x_g]});
        end
    end

    // Recorder of observed DUT events for the directed literal checks.
    int glog[$], gcyc[$];
    int rsp_cnt = 0, rsp_cyc = 0, rec_lows = 0;
    logic [31:0] l_res;
    logic [1:0]  l_id;
    logic l_par, l_perr, l_to;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) begin glog.push_back(i); gcyc.push_back(cyc); end
        if (rsp_valid != 0) begin
            rsp_cnt++; rsp_cyc = cyc;
            l_id = rsp_id; l_res = rsp_result; l_par = rsp_result_parity;
            l_perr = rsp_parity_error; l_to = rsp_timeout;
        end
        if (!m_rst_n && !rst) rec_lows++;
    end

    function automatic void set_op(int i, logic [15:0] a, logic ap, logic [15:0] b, logic bp);
        op_a[i] = a; op_ap[i] = ap; op_b[i] = b; op_bp[i] = bp;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (issued[i] < want[i]) return 1;
        return 0;
    endfunction

    task automatic wait_done(int lim);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while ((busy || pending()) && n < lim);
        chk("done_in_time", 32'(n < lim), 1);
        @(posedge clk); #1;
    endtask

    int base, lows0, r0;
    int exp_f[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 0, 2};

    initial begin
        for (int i = 0; i < N; i++) begin
            set_op(i, 16'(i * 100 + 7), ^(16'(i * 100 + 7)), 16'(-(i + 3)), ^(16'(-(i + 3))));
            want[i] = 2;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        wait_done(200);
        want[0] = 4; want[2] = 4;
        wait_done(200);
        chk("fair_count", 32'(glog.size()), 12);
        for (int k = 0; k < 12 && k < glog.size(); k++) chk("fair_order", 32'(glog[k]), 32'(exp_f[k]));

        set_op(1, 16'd3, 1'b0, 16'hFFFB, 1'b1);
        ack_d = 0; res_d = 2; base = glog.size();
        want[1]++;
        wait_done(100);
        chk("single_ready_pulses", 32'(glog.size() - base), 1);
        chk("single_id", 32'(l_id), 1);
        chk("single_result", l_res, 32'hFFFFFFF1);
        chk("single_parity", 32'(l_par), 1);
        chk("single_flags", {30'd0, l_perr, l_to}, 0);
        chk("single_latency", 32'(rsp_cyc - gcyc[base]), 3);

        set_op(3, 16'hFFFE, 1'b1, 16'd7, 1'b1);
        res_d = 1; base = glog.size();
        want[3]++;
        wait_done(100);
        chk("min_result", l_res, 32'hFFFFFFF2);
        chk("min_latency", 32'(rsp_cyc - gcyc[base]), 2);

        set_op(0, 16'h0001, 1'b0, 16'h0002, 1'b1);
        res_d = 2;
        want[0]++;
        wait_done(100);
        chk("perr_flag", 32'(l_perr), 1);
        chk("perr_result", l_res, 0);
        set_op(0, 16'd5, 1'b0, 16'd6, 1'b0);
        set_op(1, 16'd9, 1'b0, 16'd10, 1'b0);
        base = glog.size();
        want[0]++; want[1]++;
        wait_done(100);
        chk("perr_ptr_next", 32'(glog[base]), 1);
        chk("perr_ptr_after", 32'(glog[base + 1]), 0);

        set_op(2, 16'd11, 1'b1, 16'd13, 1'b1);
        res_never = 1; lows0 = rec_lows; base = glog.size();
        want[2]++;
        wait_done(300);
        chk("to_wait_flag", 32'(l_to), 1);
        chk("to_wait_result", l_res, 0);
        chk("to_wait_recover_cycles", 32'(rec_lows - lows0), 1);
        chk("to_wait_latency", 32'(rsp_cyc - gcyc[base]), 65);
        res_never = 0; ack_never = 1; lows0 = rec_lows; base = glog.size();
        want[2]++;
        wait_done(300);
        chk("to_issue_flag", 32'(l_to), 1);
        chk("to_issue_result", l_res, 0);
        chk("to_issue_recover_cycles", 32'(rec_lows - lows0), 1);
        chk("to_issue_latency", 32'(rsp_cyc - gcyc[base]), 65);
        ack_never = 0; res_d = 3;
        want[2]++;
        wait_done(100);
        chk("after_to_flag", 32'(l_to), 0);
        chk("after_to_result", l_res, 32'd143);

        res_d = 63; lows0 = rec_lows; base = glog.size();
        want[2]++;
        wait_done(300);
        chk("edge_to_flag", 32'(l_to), 0);
        chk("edge_result", l_res, 32'd143);
        chk("edge_no_recover", 32'(rec_lows - lows0), 0);
        chk("edge_latency", 32'(rsp_cyc - gcyc[base]), 64);

        early = 1; ack_d = 2; res_d = 1; base = glog.size();
        want[2]++;
        wait_done(100);
        chk("early_result", l_res, 32'd143);
        chk("early_latency", 32'(rsp_cyc - gcyc[base]), 4);
        early = 0; ack_d = 0;

        res_never = 1; r0 = rsp_cnt;
        want[2]++;
        repeat (6) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outputs", {rsp_result[29:0], m_req, |rsp_valid}, 0);
        repeat (3) @(posedge clk);
        #1 chk("rst_no_rsp", 32'(rsp_cnt - r0), 0);
        res_never = 0; res_d = 1;
        set_op(0, 16'd2, 1'b1, 16'd2, 1'b1);
        set_op(3, 16'd4, 1'b1, 16'd4, 1'b1);
        base = glog.size();
        want[0]++; want[3]++;
        wait_done(100);
        chk("rst_ptr_first", 32'(glog[base]), 0);
        chk("rst_ptr_second", 32'(glog[base + 1]), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
